decoder_sel_sequencer: RTL
==========================

Name: decoder_sel_sequencer

Overview:
Parametrised, registered successor to the team's 3-to-8 enable-gated tri-state decoder. It decodes a SEL_W-bit select into a one-hot OUT_W-bit tri-state output. It inserts a programmable high-impedance turnaround gap whenever the driven line changes, so two downstream drivers never overlap. It also has an auto-scan mode that steps through all outputs with a programmable dwell time, for bus polling and lamp/row multiplexing.

Parameters:
SEL_W, 3, select width; OUT_W = 2**SEL_W (derived, not overridable)
GAP, 1, turnaround cycles with res fully Z between two different driven codes; legal 0..15
DWELL_W, 8, width of the dwell input

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en  input  1  enable, active-low; 1 forces res to Z
sel  input  SEL_W  requested select code, sampled when req=1
req  input  1  single-cycle request to load sel (manual mode only)
scan_mode  input  1  0 = manual (req-driven), 1 = auto-scan
dwell  input  DWELL_W  auto-scan drive time per code, in cycles minus 1
res  output (tri)  OUT_W  one-hot output when driving, all-Z otherwise
cur_sel  output  SEL_W  code currently driven or pending
valid  output  1  1 exactly when res is driving a one-hot value
busy  output  1  1 while in GAP state

Behaviour:
- Clock and reset: one clock domain. rst is synchronous and active-high; rst dominates all other inputs.
- Reset values: state=IDLE, res=all Z, cur_sel=0, valid=0, busy=0, gap and dwell counters=0.
- FSM states:
  - IDLE: res=Z, valid=0, busy=0.
  - GAP: res=Z, valid=0, busy=1; the gap counter counts GAP cycles.
  - DRIVE: res=one-hot(cur_sel), valid=1, busy=0.
- Output encoding: res is driven from registers only, with no combinational path from sel or en. When driving, all OUT_W bits are driven and exactly one bit is 1. When not driving, all bits are Z; partial Z is never allowed.
- en=1 override: takes effect at the next edge and wins over everything except rst. The state goes to IDLE, so res=Z and valid=0 one cycle after en rises. req is ignored while en=1. cur_sel is held.
- Manual mode (scan_mode=0, en=0):
  - IDLE + req: cur_sel<=sel, go to GAP.
  - GAP + req: cur_sel<=sel; the gap counter is not restarted.
  - DRIVE + req with sel != cur_sel: cur_sel<=sel, go to GAP.
  - DRIVE + req with sel == cur_sel: ignored; no gap, res unchanged.
  - GAP completion: after GAP cycles in GAP, go to DRIVE.
  - Latency: res shows the one-hot code GAP+1 edges after the edge that samples req.
  - GAP=0: GAP state is skipped; IDLE/DRIVE go straight to DRIVE with the new code at the next edge (1-cycle latency). busy is never asserted.
- Auto-scan (scan_mode=1, en=0):
  - IDLE: go to GAP with the current cur_sel.
  - DRIVE: drives for dwell+1 cycles, then cur_sel<=cur_sel+1 modulo OUT_W (wraps OUT_W-1 to 0) and the block enters GAP.
  - dwell=0 gives one drive cycle per code. dwell is sampled on each entry to DRIVE.
  - req is ignored.
- Mode changes:
  - scan_mode 1->0: the current DRIVE is held indefinitely; a pending GAP completes into DRIVE.
  - scan_mode 0->1 while in DRIVE: the dwell count starts from that cycle.
- Simultaneous events: rst > en=1 > scan_mode stepping > req.
- Reset mid-GAP or mid-DRIVE: IDLE and res=Z at the same edge; no half-completed gap is carried over.
- Counters: gap counter 4 bits, dwell counter DWELL_W bits; both saturate-free and reloaded on each state entry.

Test Plan:
- Reset and idle: rst=1 for 2 cycles with en=0, req=0 -> res=8'bzzzzzzzz, valid=0, busy=0, cur_sel=0.
- Manual request, GAP=1: en=0, req with sel=3'b101 -> busy=1 for 1 cycle with res Z, then res=8'b00100000 and valid=1 on the 2nd edge after req.
- Code change and same code: while driving 3'b101, req sel=3'b010 -> exactly 1 Z cycle, then res=8'b00000100. Then req sel=3'b010 again -> no Z cycle, res unchanged.
- Enable override and reset: while driving 3'b010, en=1 -> res all Z next cycle and valid=0. Then en=0 with a req -> normal gap and drive. rst mid-GAP -> IDLE, res Z, cur_sel=0.
- Auto-scan with wrap: scan_mode=1, dwell=2, GAP=1, from cur_sel=6 -> res=8'b01000000 for 3 cycles, Z 1 cycle, 8'b10000000 for 3 cycles, Z 1 cycle, then 8'b00000001 (wrap). req pulses during the scan are ignored.
- GAP=0 build, SEL_W=4: req sel=4'hF -> res=16'h8000 one edge later; busy never 1; one-hot checked on every cycle with valid=1.

Source files
------------

// File: rtl/decoder_sel_sequencer.sv
// Registered one-hot tri-state select decoder with a high-Z turnaround gap
// between different driven codes, plus an auto-scan mode with a programmable
// dwell time per code.
module decoder_sel_sequencer #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned GAP     = 1,
  parameter int unsigned DWELL_W = 8,
  localparam int unsigned OUT_W  = 2 ** SEL_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic               req_i,
  input  logic               scan_mode_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output tri   [OUT_W-1:0]   res_o,
  output logic [SEL_W-1:0]   cur_sel_o,
  output logic               valid_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {StIdle, StGap, StDrive} state_e;

  // Last gap count value; unused when GAP is 0 because the gap state is skipped.
  localparam logic [3:0] GapLast = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0] dwell_lim_q, dwell_lim_d;
  logic [OUT_W-1:0]   res_q, res_d;
  logic               drive_q, drive_d;
  logic               busy_q, busy_d;

  logic               launch;       // switch to a new code (through the gap if any)
  logic               enter_drive;  // entering DRIVE this edge: reload dwell

  // Next-state logic; priority is en override, then scan stepping, then req.
  always_comb begin
    state_d     = state_q;
    cur_sel_d   = cur_sel_q;
    gap_cnt_d   = gap_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    dwell_lim_d = dwell_lim_q;
    launch      = 1'b0;
    enter_drive = 1'b0;

    if (en_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (scan_mode_i) begin
            launch = 1'b1;
          end else if (req_i) begin
            cur_sel_d = sel_i;
            launch    = 1'b1;
          end
        end
        StGap: begin
          // A late manual request retargets the pending code without restarting the gap.
          if (!scan_mode_i && req_i) begin
            cur_sel_d = sel_i;
          end
          if (gap_cnt_q == GapLast) begin
            state_d     = StDrive;
            enter_drive = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q + 4'd1;
          end
        end
        StDrive: begin
          if (scan_mode_i) begin
            if (dwell_cnt_q == dwell_lim_q) begin
              cur_sel_d = cur_sel_q + SEL_W'(1);
              launch    = 1'b1;
            end else begin
              dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
            end
          end else begin
            // Keep the dwell window armed so a switch into scan counts from that cycle.
            dwell_cnt_d = '0;
            dwell_lim_d = dwell_i;
            if (req_i && (sel_i != cur_sel_q)) begin
              cur_sel_d = sel_i;
              launch    = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (launch) begin
      if (GAP == 0) begin
        state_d     = StDrive;
        enter_drive = 1'b1;
      end else begin
        state_d   = StGap;
        gap_cnt_d = '0;
      end
    end

    if (enter_drive) begin
      dwell_cnt_d = '0;
      dwell_lim_d = dwell_i;
    end
  end

  // Output registers are computed from the next state so res never sees sel/en directly.
  always_comb begin
    drive_d = (state_d == StDrive);
    busy_d  = (state_d == StGap);
    res_d   = {{(OUT_W-1){1'b0}}, 1'b1} << cur_sel_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cur_sel_q   <= '0;
      gap_cnt_q   <= '0;
      dwell_cnt_q <= '0;
      dwell_lim_q <= '0;
      res_q       <= '0;
      drive_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_sel_q   <= cur_sel_d;
      gap_cnt_q   <= gap_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      dwell_lim_q <= dwell_lim_d;
      res_q       <= res_d;
      drive_q     <= drive_d;
      busy_q      <= busy_d;
    end
  end

  // All bits driven or all bits released together.
  assign res_o     = drive_q ? res_q : {OUT_W{1'bz}};
  assign cur_sel_o = cur_sel_q;
  assign valid_o   = drive_q;
  assign busy_o    = busy_q;

endmodule
